// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring radix-2 divider and sequencer for DIV/DIVU.
// Produces one quotient bit per cycle and returns {hi = remainder, lo = quotient}.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a divide request; operands latched on acceptance
// RUN   | iterating, one quotient bit per cycle, DW cycles total
// DZERO | divisor was zero; result forced to 0
// FIN   | done pulse; result register valid
module div_seq #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_div,
    input  logic [DW-1:0]   opa,
    input  logic [DW-1:0]   opb,
    input  logic            annul,
    output logic            stall,
    output logic            done,
    output logic [2*DW-1:0] result
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, RUN, DZERO, FIN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [DW-1:0]   rem, quo, dvsr;
    logic            neg_q, neg_r;

    logic            accept;
    logic            last;
    logic [DW-1:0]   mag_a, mag_b;
    logic [DW:0]     rem_sh, trial;
    logic [DW-1:0]   rem_step, quo_step;
    logic [DW-1:0]   fix_q, fix_r;

    // Operand magnitudes and one restoring step; the trial subtract is DW+1 bits
    // wide because the shifted partial remainder can exceed DW bits.
    always_comb begin
        accept   = (state == IDLE) && start && !annul;
        last     = (count == CW'(DW - 1));
        mag_a    = (signed_div && opa[DW-1]) ? -opa : opa;
        mag_b    = (signed_div && opb[DW-1]) ? -opb : opb;
        rem_sh   = {rem, quo[DW-1]};
        trial    = rem_sh - {1'b0, dvsr};
        rem_step = trial[DW] ? rem_sh[DW-1:0] : trial[DW-1:0];
        quo_step = {quo[DW-2:0], ~trial[DW]};
        fix_q    = neg_q ? -quo_step : quo_step;
        fix_r    = neg_r ? -rem_step : rem_step;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and pipeline handshake outputs; annul drops stall at once.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) state_nxt = (opb == '0) ? DZERO : RUN;
            end
            RUN: begin
                stall = !annul;
                if (annul)     state_nxt = IDLE;
                else if (last) state_nxt = FIN;
            end
            DZERO: begin
                stall     = !annul;
                state_nxt = annul ? IDLE : FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, and result capture on the way into FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && opb != '0) begin
                        rem   <= '0;
                        quo   <= mag_a;
                        dvsr  <= mag_b;
                        neg_q <= signed_div & (opa[DW-1] ^ opb[DW-1]);
                        neg_r <= signed_div & opa[DW-1];
                        count <= '0;
                    end
                end
                RUN: begin
                    if (!annul) begin
                        rem   <= rem_step;
                        quo   <= quo_step;
                        count <= count + 1'b1;
                        if (last) result <= {fix_r, fix_q};
                    end
                end
                DZERO: begin
                    if (!annul) result <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq.
module tb_div_seq;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst, start, signed_div, annul;
    logic [DW-1:0]   opa, opb;
    logic            stall, done;
    logic [2*DW-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [63:0] last_res = '0;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    div_seq #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .annul      (annul),
        .stall      (stall),
        .done       (done),
        .result     (result)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Scoreboard: every done pulse pops one expectation and checks value and timing.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("result", result, e.res);
                check_val("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp_res, input bit scramble);
        int  t0, stall_cnt;
        bit  got;
        @(negedge clk);
        opa = a; opb = b; signed_div = sgn; start = 1'b1;
        t0 = cyc;
        sb_q.push_back('{exp_res, t0 + ((b == 0) ? 2 : DW + 1)});
        stall_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            #1;
            if (stall) stall_cnt++;
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                if (scramble) begin
                    opa = $urandom; opb = $urandom; signed_div = ~sgn;
                end
            end
        end
        if (!got) check_val("timeout", {63'd0, done}, 64'd1);
        check_val("stall_cycles", 64'(stall_cnt), 64'((b == 0) ? 2 : DW + 1));
        @(negedge clk);
        start = 1'b0;
        #1;
        check_val("stall_idle", {63'd0, stall}, 64'd0);
        last_res = exp_res;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_stall",  {63'd0, stall}, 64'd0);
        check_val("rst_done",   {63'd0, done},  64'd0);
        check_val("rst_result", result,         64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_div(32'd100,        32'd7,          1'b0, {32'd2, 32'd14}, 1'b0);
        do_div(32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        do_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0, 32'h8000_0000}, 1'b0);
        do_div(32'hFFFF_FFFF,  32'd1,          1'b0, {32'd0, 32'hFFFF_FFFF}, 1'b0);
        do_div(32'd5,          32'd9,          1'b0, {32'd5, 32'd0}, 1'b0);
        do_div(32'h1234_5678,  32'd0,          1'b1, 64'd0, 1'b0);
        do_div(32'h1234_5678,  32'h0000_1234,  1'b0, model(32'h1234_5678, 32'h0000_1234, 1'b0), 1'b1);
        do_div(32'h8765_4321,  32'h0000_0013,  1'b1, model(32'h8765_4321, 32'h0000_0013, 1'b1), 1'b1);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            rs = 1'($urandom_range(0, 1));
            do_div(ra, rb, rs, model(ra, rb, rs), 1'b0);
        end

        // Annul mid-iteration: no done, stall drops in the annul cycle, result kept.
        @(negedge clk);
        opa = 32'd100; opb = 32'd7; signed_div = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        #1;
        check_val("annul_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        #1;
        check_val("annul_stall_after", {63'd0, stall}, 64'd0);
        repeat (40) @(negedge clk);
        check_val("annul_result_kept", result, last_res);
        do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0);

        // Reset mid-iteration: outputs cleared, no done afterwards.
        @(negedge clk);
        opa = 32'hDEAD_BEEF; opb = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        #1;
        check_val("midrst_stall",  {63'd0, stall}, 64'd0);
        check_val("midrst_done",   {63'd0, done},  64'd0);
        check_val("midrst_result", result,         64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 1'b0);

        repeat (3) @(negedge clk);
        check_val("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
